// File: rtl/player_btn_conditioner_pkg.sv
// Shared definitions for the player button conditioner: button indices,
// repeat-FSM state encoding and a counter-width helper.
package player_btn_conditioner_pkg;

    localparam int unsigned BTN_UP    = 0;
    localparam int unsigned BTN_DOWN  = 1;
    localparam int unsigned BTN_LEFT  = 2;
    localparam int unsigned BTN_RIGHT = 3;
    localparam int unsigned NUM_BTNS  = BTN_RIGHT + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } rpt_state_e;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/player_btn_conditioner_debounce.sv
// One button lane: two-flop synchronizer followed by a stability counter
// that accepts a new level only after it has held for DEBOUNCE_CYCLES clocks.
module btn_debounce
    import player_btn_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            stable_d = sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/player_btn_conditioner.sv
// Debounces the four pad buttons and produces the btns snapshot plus the
// btnClk2 step strobe, with press-to-step and hold-to-repeat behaviour.
module player_btn_conditioner
    import player_btn_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned HOLD_CYCLES     = 30_000_000,
    parameter int unsigned REPEAT_CYCLES   = 10_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_BTNS-1:0] btns_raw,
    output logic [NUM_BTNS-1:0] btns,
    output logic                btnClk2,
    output logic                held
);

    localparam int unsigned TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned TW   = cnt_width(TMAX);

    logic [NUM_BTNS-1:0] db;
    logic                pressed, blocked, step_req;
    rpt_state_e          state_q, state_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [NUM_BTNS-1:0] btns_q, btns_d;
    logic                step_q, btn_clk2_q, held_q, held_d;

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_db
        btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk    (clk),
            .rst    (rst),
            .raw    (btns_raw[i]),
            .stable (db[i])
        );
    end

    assign pressed = |db;
    // The cycle after a step is reserved so btnClk2 can never be high twice in a row
    // and btns stays put across the strobe's rising edge.
    assign blocked = step_q;

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        btns_d   = btns_q;
        step_req = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!blocked) begin
                    if (pressed) begin
                        step_req = 1'b1;
                        state_d  = ST_HOLD;
                    end else begin
                        btns_d = '0;
                    end
                end
            end
            ST_HOLD, ST_REPEAT: begin
                if (!pressed) begin
                    state_d = ST_IDLE;
                    if (!blocked) btns_d = '0;
                end else if (db != btns_q && !blocked) begin
                    step_req = 1'b1;
                    state_d  = ST_HOLD;
                end else if (timer_q == ((state_q == ST_HOLD) ? TW'(HOLD_CYCLES - 1)
                                                                : TW'(REPEAT_CYCLES - 1))) begin
                    step_req = 1'b1;
                    state_d  = ST_REPEAT;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (step_req) begin
            btns_d  = db;
            timer_d = '0;
        end
        held_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            btns_q     <= '0;
            step_q     <= 1'b0;
            btn_clk2_q <= 1'b0;
            held_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            btns_q     <= btns_d;
            step_q     <= step_req;
            btn_clk2_q <= step_q;
            held_q     <= held_d;
        end
    end

    assign btns    = btns_q;
    assign btnClk2 = btn_clk2_q;
    assign held    = held_q;

endmodule
